// File: rtl/base_arr_wrr_arb.sv
// base_arr_wrr_arb: weighted round-robin, packet-aware arbiter.
// Each way may send up to its quota of whole packets per turn before
// priority rotates. Multi-beat packets keep the grant until their last beat.
// o_s is a one-hot select that drives a downstream data mux.
module base_arr_wrr_arb #(
    parameter int ways  = 4,
    parameter int wbits = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ways-1]       i_v,
    output logic [0:ways-1]       i_r,
    input  logic [0:ways-1]       i_h,
    input  logic [0:ways*wbits-1] i_q,
    output logic                  o_v,
    input  logic                  o_r,
    output logic                  o_h,
    output logic [0:ways-1]       o_s
);
    localparam int pbits = (ways > 1) ? $clog2(ways) : 1;

    typedef logic [pbits-1:0] way_t;
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t           state, state_n;
    way_t             ptr, ptr_n;
    way_t             owner, owner_n;
    logic [wbits-1:0] used, used_n;

    way_t             gnt;
    way_t             cand;
    logic             found;
    logic             gv;
    logic             xfer;
    logic [wbits:0]   n;
    logic [wbits:0]   qe;
    logic [wbits-1:0] quota [ways];

    // Split the flat quota bus into one field per way (way k at k*wbits).
    for (genvar k = 0; k < ways; k++) begin : g_quota
        assign quota[k] = i_q[k*wbits +: wbits];
    end

    // Grant selection: locked owner, else first valid way at or after ptr.
    always_comb begin
        found = 1'b0;
        gnt   = ptr;
        cand  = '0;
        if (state == LOCKED) begin
            found = 1'b1;
            gnt   = owner;
        end else begin
            for (int unsigned i = 0; i < ways; i++) begin
                cand = way_t'((32'(ptr) + i) % 32'(ways));
                if (!found && i_v[cand]) begin
                    found = 1'b1;
                    gnt   = cand;
                end
            end
        end
        gv = found & i_v[gnt];
    end

    // Handshake outputs, all forced quiet while reset is asserted.
    always_comb begin
        o_s = '0;
        if (!reset && found) begin
            o_s[gnt] = 1'b1;
        end
        o_v  = !reset && gv;
        o_h  = o_v & i_h[gnt];
        i_r  = o_s & {ways{o_r}};
        xfer = o_v & o_r;
    end

    // Next-state: lock on mid-packet beats, count packets at packet end.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        used_n  = used;
        owner_n = owner;
        n       = (gnt == ptr) ? ({1'b0, used} + 1'b1) : {{wbits{1'b0}}, 1'b1};
        qe      = (quota[gnt] == '0) ? {{wbits{1'b0}}, 1'b1} : {1'b0, quota[gnt]};
        if (xfer) begin
            if (i_h[gnt]) begin
                state_n = LOCKED;
                owner_n = gnt;
            end else begin
                state_n = UNLOCKED;
                if (n >= qe) begin
                    ptr_n  = (gnt == way_t'(ways - 1)) ? '0 : gnt + 1'b1;
                    used_n = '0;
                end else begin
                    ptr_n  = gnt;
                    used_n = n[wbits-1:0];
                end
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNLOCKED;
            ptr   <= '0;
            used  <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            used  <= used_n;
            owner <= owner_n;
        end
    end

endmodule

// File: tb/tb_base_arr_wrr_arb.sv
// Testbench for base_arr_wrr_arb: directed scenarios with a queue of
// expected per-cycle outputs compared mid-cycle.
module tb_base_arr_wrr_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:3]  i_v = '0;
    logic [0:3]  i_r;
    logic [0:3]  i_h = '0;
    logic [0:15] i_q = 16'h1111;
    logic        o_v;
    logic        o_r = 1'b0;
    logic        o_h;
    logic [0:3]  o_s;

    typedef struct packed {
        logic [0:3] s;
        logic       v;
        logic       h;
        logic [0:3] r;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    base_arr_wrr_arb #(.ways(4), .wbits(4)) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_h   (i_h),
        .i_q   (i_q),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_h   (o_h),
        .o_s   (o_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [0:3] oh(input int w);
        logic [0:3] r;
        r    = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    // Drive one cycle at the falling edge, queue its expectation, compare
    // well before the next rising edge.
    task automatic step(input logic rst, input logic [0:3] v, input logic [0:3] h,
                        input logic r, input logic [0:3] es, input logic ev,
                        input logic eh, input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst;
        i_v   = v;
        i_h   = h;
        o_r   = r;
        e.s = es;
        e.v = ev;
        e.h = eh;
        e.r = es & {4{r}};
        exp_q.push_back(e);
        #2;
        e = exp_q.pop_front();
        check({tag, ".o_s"}, 32'(o_s), 32'(e.s));
        check({tag, ".o_v"}, 32'(o_v), 32'(e.v));
        check({tag, ".o_h"}, 32'(o_h), 32'(e.h));
        check({tag, ".i_r"}, 32'(i_r), 32'(e.r));
    endtask

    task automatic do_reset(input logic [0:15] q);
        i_q = q;
        step(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, "reset");
    endtask

    initial begin
        int seq1[5];
        int seq2[10];
        seq1 = '{0, 1, 2, 3, 0};
        seq2 = '{0, 0, 0, 1, 2, 3, 3, 0, 0, 0};

        // 1: equal quotas rotate one packet per way
        do_reset(16'h1111);
        foreach (seq1[j])
            step(1'b0, 4'b1111, 4'b0000, 1'b1, oh(seq1[j]), 1'b1, 1'b0, "equal");

        // 2: weighted quotas {3,1,0,2}, zero quota acts as one
        do_reset(16'h3102);
        foreach (seq2[j])
            step(1'b0, 4'b1111, 4'b0000, 1'b1, oh(seq2[j]), 1'b1, 1'b0, "weighted");

        // 3: way1 three-beat packet with a valid gap, then way2 wins
        do_reset(16'h1111);
        step(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, "lock_b1");
        step(1'b0, 4'b1110, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, "lock_b2");
        step(1'b0, 4'b1010, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, "lock_gap");
        step(1'b0, 4'b1110, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, "lock_b3");
        step(1'b0, 4'b1110, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, "lock_after");

        // 4: backpressure keeps ptr/used; way0 quota 2 resumes its second packet
        do_reset(16'h2111);
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, "bp_first");
        for (int j = 0; j < 5; j++)
            step(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, "bp_stall");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, "bp_resume");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, "bp_next");

        // 5: idle priority way hands over; way2 quota 1 moves ptr to 3
        do_reset(16'h3111);
        step(1'b0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, "idle_w0");
        step(1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0, "idle_w2");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0, "idle_w3");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, "idle_w0b");

        // 6: async reset while locked on way3, then arbitration restarts at way0
        do_reset(16'h1111);
        step(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, "rst_lock");
        step(1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, "rst_held");
        step(1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, "rst_async");
        step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, "rst_after");

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/base_arr_wrr_arb.md
# base_arr_wrr_arb

Weighted round-robin, packet-aware arbiter that shares one downstream valid/ready channel between `ways` requesters. Each way is granted up to its programmed quota of packets per turn before priority rotates. Multi-beat packets hold the grant until their last beat. The block produces a one-hot select that drives a `base_mux`-style data mux. It replaces the plain round-robin arbiter wherever bandwidth must be split unevenly between ports.

## Interface
Parameters:
- `ways`, 4: number of requesters (>=2).
- `wbits`, 4: quota and counter width per way.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `i_v`  in  [0:ways-1]  requester valid; bit k = way k.
- `i_r`  out  [0:ways-1]  requester ready.
- `i_h`  in  [0:ways-1]  hold: 1 = current beat is not the last of its packet.
- `i_q`  in  [0:ways*wbits-1]  per-way quota in packets per turn. Way k is bits `[k*wbits : k*wbits+wbits-1]`. A value of 0 is treated as 1.
- `o_v`  out  1  downstream valid.
- `o_r`  in  1  downstream ready.
- `o_h`  out  1  hold of the granted beat, forwarded downstream.
- `o_s`  out  [0:ways-1]  one-hot grant, or all zero when nothing is granted.

## Operation
State registers, all cleared by `reset`:
- `ptr` (priority way): reset 0.
- `used` (packets consumed by `ptr` this turn): reset 0.
- `lock` (mid-packet): reset 0.
- `owner` (locked way): reset 0.

Grant selection:
- UNLOCKED (`lock`=0): grant the first way with `i_v`=1, searching `ptr`, `ptr`+1, … and wrapping modulo `ways`. If no way is valid, `o_s`=0 and `o_v`=0.
- LOCKED (`lock`=1): `o_s` = one-hot(`owner`) regardless of `i_v`, and `o_v` = `i_v[owner]`. No other way is granted, even if the owner drops valid mid-packet.

Outputs:
- `i_r[k]` = `o_s[k]` & `o_r`.
- `o_h` = `i_h[g]`, where g is the granted way; `o_h`=0 when `o_v`=0.

A transfer occurs when `o_v` & `o_r`. On a transfer by way g:
- If `i_h[g]`=1: set `lock`=1 and `owner`=g. `ptr` and `used` are unchanged.
- If `i_h[g]`=0 (packet end): set `lock`=0. Compute n = (g==`ptr`) ? `used`+1 : 1, and qe = max(`i_q[g]`, 1).
  - If n >= qe: `ptr` = (g+1) mod `ways`, `used` = 0.
  - Otherwise: `ptr` = g, `used` = n.

Boundary rules:
- Quota counts whole packets, not beats.
- If the priority way is idle, the next valid way is granted and starts a fresh count (n=1). The old way's partial count is discarded.
- `i_q` is sampled only at packet end. A quota change takes effect at the next packet-end comparison.
- `used` never exceeds 2^wbits−1; qe is at most 2^wbits−1, so n cannot overflow.
- Single-beat packets (`i_h`=0) never lock.

## Timing
- Grant is combinational from `i_v`/`i_h`/state, with zero-cycle latency. A valid request is granted in the same cycle if it wins.
- Back-to-back transfers are possible every cycle, including a switch between ways on consecutive cycles.
- When `o_r`=0, state holds and `o_s` may still change with `i_v` while unlocked. In LOCKED, `o_s` is stable.
- While `reset`=1: `o_v`=0, `o_h`=0, `o_s`=0, `i_r`=0, with state forced to reset values.
- A mid-packet reset abandons the lock. The first cycle after release arbitrates from `ptr`=0.
- Requesters must hold `i_v`, `i_h` and data stable until their `i_r`=1.

## Test plan
Use `ways`=4 and `wbits`=4 throughout.
1. Equal quotas, `i_q`={1,1,1,1}, all `i_v`=1, `i_h`=0, `o_r`=1 -> `o_s` sequence 1000, 0100, 0010, 0001, 1000.
2. Weighted quotas, `i_q`={3,1,0,2}, all valid, single-beat -> grant sequence 0,0,0,1,2,3,3,0,0,0.
3. Lock: way1 sends a 3-beat packet with `i_h`=1,1,0 while ways 0 and 2 are valid. Drop `i_v[1]` for one cycle mid-packet -> `o_s`=0100 throughout and `o_v`=0 in the gap. After the last beat, way 2 is granted (`ptr`=2).
4. Backpressure: all valid, `o_r`=0 for 5 cycles -> `i_r`=0000, and `ptr`/`used` are unchanged. After `o_r` rises, the grant continues where it stopped.
5. Idle priority way: `i_q`[0]=3. Way0 sends 1 packet then drops valid; way2 is valid with `i_q`[2]=1 -> way2 is granted, and after its packet end `ptr`=3 and `used`=0.
6. Asynchronous reset asserted mid-packet while locked on way3 -> `o_v`/`o_s`/`i_r` go to 0 immediately without a clock edge. After release with all ways valid, the first grant is way0.
